mem_access_controller: RTL and testbench
========================================

Name: mem_access_controller

Overview:
- Parametrised second-generation CPU memory controller. Sits between the CPU load/store unit and the RAM, I/O and cache ports.
- Replaces tri-state buses with a valid/ready request channel and a valid/ready response channel.
- Latches each request and decodes it to a RAM, I/O, ROM or cache-hit path. Adds ROM write protection, bounded timeout with an error response, and one outstanding transaction.

Parameters:
- ADDR_W, 16, CPU address width in bits.
- DATA_W, 8, data width in bits.
- IO_BASE, 'hF000, first address of the I/O window (ADDR_W bits).
- IO_AW, 8, I/O window is 2^IO_AW bytes; io_addr width.
- ROM_BASE, 'hF100, addresses >= ROM_BASE are read-only.
- CACHE_TOP, 'hEFFF, addresses <= CACHE_TOP are cacheable.
- TIMEOUT_CYC, 8, downstream cycles waited before an error completion (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU request valid
- req_ready  out  1  controller can accept a request
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  CPU accepts response
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  1 = ROM write or timeout
- mem_req  out  1  RAM/ROM access strobe (level)
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- mem_ack  in  1  RAM access complete
- io_req  out  1  I/O access strobe (level)
- io_we  out  1  I/O write enable
- io_addr  out  IO_AW  I/O offset
- io_wdata  out  DATA_W  I/O write data
- io_rdata  in  DATA_W  I/O read data
- io_ack  in  1  I/O access complete
- cache_en  out  1  current req_addr is cacheable (combinational)
- cache_hit  in  1  cache hit for req_addr, same cycle
- cache_rdata  in  DATA_W  cache read data, same cycle

Behaviour:
- Reset (async): state=IDLE. Outputs req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0. mem_req=io_req=mem_we=io_we=0. All latched address/data=0. Timeout counter=0.
- Decode from req_addr:
  - I/O = IO_BASE <= addr < IO_BASE+2^IO_AW.
  - ROM = addr >= ROM_BASE and not I/O.
  - Otherwise RAM.
  - cache_en = addr <= CACHE_TOP.
- States:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready. At acceptance, latch write, addr, wdata and region, then:
    - write to ROM -> RESP, err=1, no downstream strobe.
    - read with cache_en&&cache_hit -> RESP, rdata=cache_rdata captured at acceptance.
    - I/O -> IO.
    - else -> MEM.
  - MEM/IO: req_ready=0. Strobe (mem_req or io_req) held high from the cycle after acceptance with latched addr/wdata/we. io_addr = addr[IO_AW-1:0]. Counter increments each cycle in state.
    - ack=1 -> RESP, capture rdata (reads; 0 for writes), err=0, strobe low next cycle.
    - counter == TIMEOUT_CYC-1 without ack -> RESP, err=1, rdata=0, strobe dropped.
    - ack and timeout in the same cycle: ack wins, err=0.
    - Only the ack of the selected path is observed; the other ack is ignored.
  - RESP: rsp_valid=1; rdata/err stable until handshake. On rsp_ready -> IDLE with rsp_valid low the next cycle. req_ready stays 0 in RESP, so no back-to-back overlap.
- Latency:
  - Cache hit or ROM-write error: rsp_valid the cycle after acceptance.
  - Downstream: strobe at acceptance+1; ack in cycle T gives rsp_valid at T+1. Minimum 2 cycles acceptance-to-response with zero-wait RAM.
- Changes on req_* after acceptance have no effect until the next IDLE.
- Reset mid-transaction: immediate return to reset values. The downstream strobe drops asynchronously and no response is issued.
- Counter is 8 bits and clears on entry to MEM/IO.

Test Plan:
- Read 0x1234, mem_ack 3 cycles after mem_req with mem_rdata=0xA5 -> mem_req high exactly 3 cycles; rsp_valid one cycle later with rdata=0xA5, err=0.
- Write 0xF010 data 0x3C, io_ack on first cycle -> io_req with io_addr=0x10, io_we=1, io_wdata=0x3C for 1 cycle; response err=0, rdata=0; mem_req never asserted.
- Write 0xF200 -> no mem_req/io_req; rsp_valid at acceptance+1 with err=1.
- Read 0x0100 with cache_hit=1, cache_rdata=0x77 -> no downstream strobe; rsp rdata=0x77 at acceptance+1.
- Read 0x8000, mem_ack never asserted -> mem_req high 8 cycles, then response err=1, rdata=0. A repeat run with mem_ack in the 8th cycle -> err=0.
- Hold rsp_ready=0 for 5 cycles with a second req_valid pending -> rsp stable, req_ready=0 throughout, second request accepted only after the response handshake. Assert rst_n low mid-MEM -> mem_req=0 immediately, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_controller.sv
// mem_access_controller
//   Decodes one CPU request at a time to a RAM/ROM, I/O or cache-hit path.
//   It holds a single outstanding transaction and writes a response back on a
//   valid/ready channel.
//   Writes to ROM complete with an error and never reach the memory port.
//   A downstream access that gets no ack within TIMEOUT_CYC cycles completes
//   with an error.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/ready/write/addr/wdata   CPU request channel
//   rsp_valid/ready/rdata/err          CPU response channel
//   mem_req/we/addr/wdata/rdata/ack    RAM/ROM port (level strobe)
//   io_req/we/addr/wdata/rdata/ack     I/O port (level strobe, window offset)
//   cache_en, cache_hit, cache_rdata   same-cycle cache lookup on req_addr
module mem_access_controller #(
    parameter int unsigned             ADDR_W      = 16,
    parameter int unsigned             DATA_W      = 8,
    parameter logic [ADDR_W-1:0]       IO_BASE     = ADDR_W'('hF000),
    parameter int unsigned             IO_AW       = 8,
    parameter logic [ADDR_W-1:0]       ROM_BASE    = ADDR_W'('hF100),
    parameter logic [ADDR_W-1:0]       CACHE_TOP   = ADDR_W'('hEFFF),
    parameter int unsigned             TIMEOUT_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              io_req,
    output logic              io_we,
    output logic [IO_AW-1:0]  io_addr,
    output logic [DATA_W-1:0] io_wdata,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_ack,
    output logic              cache_en,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_IO   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // One bit wider than the address so the end of a window at the top of
    // the address space does not wrap.
    localparam logic [ADDR_W:0] IO_LIMIT = {1'b0, IO_BASE} + ((ADDR_W+1)'(1) << IO_AW);
    localparam logic [7:0]      CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    logic in_io, in_rom;

    assign in_io    = (req_addr >= IO_BASE) && ({1'b0, req_addr} < IO_LIMIT);
    assign in_rom   = (req_addr >= ROM_BASE) && !in_io;
    assign cache_en = (req_addr <= CACHE_TOP);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (req_write && in_rom) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!req_write && cache_en && cache_hit) begin
                        rdata_d = cache_rdata;
                        state_d = S_RESP;
                    end else if (in_io) begin
                        state_d = S_IO;
                    end else begin
                        state_d = S_MEM;
                    end
                end
            end
            S_MEM, S_IO: begin
                // An ack on the last allowed cycle still completes cleanly.
                if ((state_q == S_MEM) ? mem_ack : io_ack) begin
                    rdata_d = we_q ? '0 : ((state_q == S_MEM) ? mem_rdata : io_rdata);
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        mem_req   = (state_q == S_MEM);
        mem_we    = (state_q == S_MEM) && we_q;
        io_req    = (state_q == S_IO);
        io_we     = (state_q == S_IO) && we_q;
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign io_addr   = addr_q[IO_AW-1:0];
    assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller with default parameters.
module tb_mem_access_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        io_req, io_we, io_ack;
    logic [7:0]  io_addr, io_wdata, io_rdata;
    logic        cache_en, cache_hit;
    logic [7:0]  cache_rdata;

    int errors = 0;
    int checks = 0;
    int hi, other_hi;

    always #5 clk = ~clk;

    mem_access_controller #(
        .ADDR_W     (16),
        .DATA_W     (8),
        .IO_BASE    (16'hF000),
        .IO_AW      (8),
        .ROM_BASE   (16'hF100),
        .CACHE_TOP  (16'hEFFF),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .io_req     (io_req),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_ack     (io_ack),
        .cache_en   (cache_en),
        .cache_hit  (cache_hit),
        .cache_rdata(cache_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in IDLE and returns just after the accepting edge,
    // then scrambles req_* to show they are ignored once accepted.
    task automatic drive_req(input logic wr, input logic [15:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        check("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 16'h5555;
        req_wdata = 8'hEE;
    endtask

    // Acts as the downstream target. Acks on the ack_at-th strobe cycle
    // (0 = never) while holding the other path's ack high to show it is ignored.
    task automatic serve(input logic use_io, input int ack_at, input logic [7:0] rd,
                         output int n_hi, output int n_other);
        n_hi    = 0;
        n_other = 0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            if (use_io ? io_req : mem_req) n_hi++;
            if (use_io ? mem_req : io_req) n_other++;
            if (use_io) begin
                mem_ack = 1'b1;
                io_ack  = (n_hi == ack_at);
                io_rdata = rd;
            end else begin
                io_ack  = 1'b1;
                mem_ack = (n_hi == ack_at);
                mem_rdata = rd;
            end
            tick();
            mem_ack = 1'b0;
            io_ack  = 1'b0;
        end
        check("rsp_arrived", rsp_valid, 1);
        check("strobe_dropped", use_io ? io_req : mem_req, 0);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("req_ready_after_hs", req_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0;
        io_rdata = '0; io_ack = 1'b0;
        cache_hit = 1'b0; cache_rdata = '0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_io_req", io_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // cacheable boundary
        req_addr = 16'hEFFF; #1;
        check("cache_en_top", cache_en, 1);
        req_addr = 16'hF000; #1;
        check("cache_en_above", cache_en, 0);
        tick();

        // RAM read, ack on 3rd strobe cycle
        drive_req(1'b0, 16'h1234, 8'h00);
        check("rd_mem_req", mem_req, 1);
        check("rd_mem_addr", mem_addr, 16'h1234);
        check("rd_mem_we", mem_we, 0);
        check("rd_req_ready_busy", req_ready, 0);
        serve(1'b0, 3, 8'hA5, hi, other_hi);
        check("rd_strobe_cycles", hi, 3);
        check("rd_io_never", other_hi, 0);
        check("rd_rdata", rsp_rdata, 8'hA5);
        check("rd_err", rsp_err, 0);
        handshake();

        // I/O write, ack on first strobe cycle
        drive_req(1'b1, 16'hF010, 8'h3C);
        check("io_req", io_req, 1);
        check("io_addr", io_addr, 8'h10);
        check("io_we", io_we, 1);
        check("io_wdata", io_wdata, 8'h3C);
        serve(1'b1, 1, 8'h99, hi, other_hi);
        check("io_strobe_cycles", hi, 1);
        check("io_mem_never", other_hi, 0);
        check("io_wr_rdata", rsp_rdata, 0);
        check("io_wr_err", rsp_err, 0);
        handshake();

        // RAM write
        drive_req(1'b1, 16'h0200, 8'hC3);
        check("ramwr_we", mem_we, 1);
        check("ramwr_wdata", mem_wdata, 8'hC3);
        serve(1'b0, 2, 8'h11, hi, other_hi);
        check("ramwr_cycles", hi, 2);
        check("ramwr_rdata", rsp_rdata, 0);
        check("ramwr_err", rsp_err, 0);
        handshake();

        // ROM write rejected with no downstream access
        drive_req(1'b1, 16'hF200, 8'h42);
        check("rom_rsp_valid", rsp_valid, 1);
        check("rom_err", rsp_err, 1);
        check("rom_rdata", rsp_rdata, 0);
        check("rom_mem_req", mem_req, 0);
        check("rom_io_req", io_req, 0);
        handshake();

        // cache hit read
        cache_hit = 1'b1;
        cache_rdata = 8'h77;
        drive_req(1'b0, 16'h0100, 8'h00);
        cache_hit = 1'b0;
        cache_rdata = 8'h00;
        check("hit_rsp_valid", rsp_valid, 1);
        check("hit_rdata", rsp_rdata, 8'h77);
        check("hit_err", rsp_err, 0);
        check("hit_mem_req", mem_req, 0);
        handshake();

        // timeout: no ack ever (other ack held high throughout)
        drive_req(1'b0, 16'h8000, 8'h00);
        serve(1'b0, 0, 8'h5A, hi, other_hi);
        check("to_strobe_cycles", hi, 8);
        check("to_err", rsp_err, 1);
        check("to_rdata", rsp_rdata, 0);
        handshake();

        // ack in the final cycle beats the timeout
        drive_req(1'b0, 16'h8000, 8'h00);
        serve(1'b0, 8, 8'h5A, hi, other_hi);
        check("late_strobe_cycles", hi, 8);
        check("late_err", rsp_err, 0);
        check("late_rdata", rsp_rdata, 8'h5A);

        // response back-pressure with a second request pending
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h2000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, 8'h5A);
            check("bp_req_ready", req_ready, 0);
            check("bp_mem_req", mem_req, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_idle_ready", req_ready, 1);
        check("bp_idle_rsp", rsp_valid, 0);
        tick();
        req_valid = 1'b0;
        check("second_mem_req", mem_req, 1);
        check("second_mem_addr", mem_addr, 16'h2000);

        // async reset mid-access
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_req_ready", req_ready, 1);
        check("arst_mem_addr", mem_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
